// File: rtl/imem_responder.sv
// Instruction fetch responder: buffers fetch PCs, forwards them in order to a
// ready/valid instruction memory and returns in-order responses; FLUSH kills in-flight work.
module imem_responder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_STALL,
    output logic        INST_RVALID,
    output logic [31:0] INST_RADDR,
    output logic [31:0] INST_RDATA,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_RADDR,
    input  logic        MEM_RREADY,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    // Handshake: a memory request transfers in any cycle where MEM_RDEN and
    // MEM_RREADY are both high; MEM_RADDR is stable while MEM_RDEN is held.
    logic [PTR_W:0]   tail_q, tail_d;
    logic [PTR_W:0]   issue_q, issue_d;
    logic [PTR_W:0]   head_q, head_d;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic             inst_rvalid_q, inst_rvalid_d;
    logic [31:0]      inst_raddr_q, inst_raddr_d;
    logic [31:0]      inst_rdata_q, inst_rdata_d;

    logic [PTR_W:0]   count;
    logic [PTR_W:0]   issued;
    logic             full;
    logic             accept;
    logic             issue_fire;
    logic             retire;
    logic [PTR_W-1:0] tail_idx;
    logic [PTR_W-1:0] issue_idx;
    logic [PTR_W-1:0] head_idx;

    assign tail_idx   = tail_q[PTR_W-1:0];
    assign issue_idx  = issue_q[PTR_W-1:0];
    assign head_idx   = head_q[PTR_W-1:0];
    assign count      = tail_q - head_q;
    assign issued     = issue_q - head_q;
    assign full       = (count == DEPTH_P);

    assign INST_STALL = full;
    assign MEM_RDEN   = (issue_q != tail_q) && !FLUSH;
    assign MEM_RADDR  = MEM_RDEN ? addr_q[issue_idx] : 32'h0;

    assign accept     = INST_RDEN && !full && !FLUSH;
    assign issue_fire = MEM_RDEN && MEM_RREADY;
    assign retire     = MEM_RVALID && (head_q != issue_q);

    assign INST_RVALID = inst_rvalid_q;
    assign INST_RADDR  = inst_raddr_q;
    assign INST_RDATA  = inst_rdata_q;

    always_comb begin
        logic [PTR_W-1:0] offs;
        tail_d        = tail_q;
        issue_d       = issue_q;
        head_d        = head_q;
        addr_d        = addr_q;
        kill_d        = kill_q;
        inst_rvalid_d = 1'b0;
        inst_raddr_d  = inst_raddr_q;
        inst_rdata_d  = inst_rdata_q;
        offs          = '0;

        if (accept) begin
            addr_d[tail_idx] = INST_RIADDR;
            kill_d[tail_idx] = 1'b0;
            tail_d           = tail_q + 1'b1;
        end

        if (issue_fire) begin
            issue_d = issue_q + 1'b1;
        end

        if (retire) begin
            head_d = head_q + 1'b1;
            if (!kill_q[head_idx] && !FLUSH) begin
                inst_rvalid_d = 1'b1;
                inst_raddr_d  = addr_q[head_idx];
                inst_rdata_d  = MEM_RDATA;
            end
        end

        // Flush drops unissued entries and marks every issued-but-unreturned slot
        // so its response retires silently when it eventually comes back.
        if (FLUSH) begin
            tail_d = issue_q;
            for (int i = 0; i < DEPTH; i++) begin
                offs = PTR_W'(i) - head_idx;
                if ({1'b0, offs} < issued) begin
                    kill_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tail_q        <= '0;
            issue_q       <= '0;
            head_q        <= '0;
            kill_q        <= '0;
            inst_rvalid_q <= 1'b0;
            inst_raddr_q  <= 32'h0;
            inst_rdata_q  <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0;
            end
        end else begin
            tail_q        <= tail_d;
            issue_q       <= issue_d;
            head_q        <= head_d;
            kill_q        <= kill_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_raddr_q  <= inst_raddr_d;
            inst_rdata_q  <= inst_rdata_d;
            addr_q        <= addr_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed test-plan scenarios followed by random
// traffic, all checked against a queue-based model of the fetch buffer and memory.
module tb_imem_responder;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, INST_RDEN, MEM_RREADY, MEM_RVALID;
    logic [31:0] INST_RIADDR, MEM_RDATA;
    logic        INST_STALL, INST_RVALID, MEM_RDEN;
    logic [31:0] INST_RADDR, INST_RDATA, MEM_RADDR;

    always #5 CLK = ~CLK;

    imem_responder #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_STALL(INST_STALL),
        .INST_RVALID(INST_RVALID), .INST_RADDR(INST_RADDR), .INST_RDATA(INST_RDATA),
        .MEM_RDEN(MEM_RDEN), .MEM_RADDR(MEM_RADDR), .MEM_RREADY(MEM_RREADY),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
    );

    // Stimulus controls
    logic        rst_i, flush_i, rden_i, rready_i, spur_i;
    logic [31:0] addr_i;
    int          lat;
    bit          rand_lat;
    int          cyc;
    bit          checks_on;
    bit          last_acc;
    int          errors;
    int          checks;

    // Reference model: pending fetches in order, how many of them reached memory
    logic [31:0] exp_q[$];
    bit          kill_mq[$];
    int          n_iss;
    logic        exp_rvalid;
    logic [31:0] exp_raddr, exp_rdata;
    // Memory: accepted requests with the cycle their response becomes due
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [PTR_W:0] dut_count();
        return dut.tail_q - dut.head_q;
    endfunction

    task automatic tick();
        logic        rv, real_rv, e_stall, e_rden, acc, iss, k;
        logic [31:0] rd, e_raddr, a;
        int          n, old_iss, l;
        real_rv = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        rv = 1'b0;
        rd = 32'h0;
        if (real_rv) begin
            rv = 1'b1;
            rd = mem_addr_q[0] ^ KEY;
        end else if (spur_i) begin
            rv = 1'b1;
            rd = $urandom();
        end
        RST = rst_i; FLUSH = flush_i; INST_RDEN = rden_i; INST_RIADDR = addr_i;
        MEM_RREADY = rready_i; MEM_RVALID = rv; MEM_RDATA = rd;

        @(negedge CLK);
        n       = exp_q.size();
        e_stall = (n == DEPTH);
        e_rden  = (n_iss < n) && !flush_i;
        e_raddr = e_rden ? exp_q[n_iss] : 32'h0;
        if (checks_on) begin
            chk("inst_stall", {31'b0, INST_STALL}, {31'b0, e_stall});
            chk("mem_rden", {31'b0, MEM_RDEN}, {31'b0, e_rden});
            chk("mem_raddr", MEM_RADDR, e_raddr);
            chk("inst_rvalid", {31'b0, INST_RVALID}, {31'b0, exp_rvalid});
            chk("inst_raddr", INST_RADDR, exp_raddr);
            chk("inst_rdata", INST_RDATA, exp_rdata);
            chk("count", {29'b0, dut_count()}, n);
        end

        acc = rden_i && !e_stall && !flush_i && !rst_i;
        iss = e_rden && rready_i;
        if (real_rv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (iss) begin
            l = rand_lat ? $urandom_range(1, 3) : lat;
            mem_addr_q.push_back(exp_q[n_iss]);
            mem_due_q.push_back(cyc + l);
        end

        if (rst_i) begin
            exp_q.delete();
            kill_mq.delete();
            n_iss = 0;
            exp_rvalid = 1'b0;
            exp_raddr = 32'h0;
            exp_rdata = 32'h0;
        end else begin
            old_iss = n_iss;
            if (iss) n_iss++;
            exp_rvalid = 1'b0;
            if (rv && old_iss > 0) begin
                a = exp_q.pop_front();
                k = kill_mq.pop_front();
                n_iss--;
                if (!k && !flush_i) begin
                    exp_rvalid = 1'b1;
                    exp_raddr = a;
                    exp_rdata = rd;
                end
            end
            if (flush_i) begin
                for (int i = 0; i < n_iss; i++) kill_mq[i] = 1'b1;
                while (exp_q.size() > n_iss) begin
                    void'(exp_q.pop_back());
                    void'(kill_mq.pop_back());
                end
            end
            if (acc) begin
                exp_q.push_back(addr_i);
                kill_mq.push_back(1'b0);
            end
        end
        last_acc = acc;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic present(input logic [31:0] a);
        int n;
        n = 0;
        rden_i = 1'b1;
        addr_i = a;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 60);
        if (!last_acc) begin
            checks++;
            errors++;
            $error("FAIL present_timeout observed=not_accepted expected=accepted addr=%h", a);
        end
        rden_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit hit;
        errors = 0; checks = 0; cyc = 0; n_iss = 0; last_acc = 0;
        exp_rvalid = 0; exp_raddr = 0; exp_rdata = 0;
        rst_i = 1; flush_i = 0; rden_i = 0; addr_i = 0; rready_i = 1; spur_i = 0;
        lat = 1; rand_lat = 0; checks_on = 0;

        // Reset
        tick();
        checks_on = 1;
        tick();
        rst_i = 0;
        chk("rst_rvalid", {31'b0, INST_RVALID}, 32'h0);
        chk("rst_stall", {31'b0, INST_STALL}, 32'h0);
        chk("rst_mem_rden", {31'b0, MEM_RDEN}, 32'h0);
        chk("rst_raddr", INST_RADDR, 32'h0);

        // Streaming at full rate with 1-cycle memory
        present(32'h0);
        present(32'h4);
        present(32'h8);
        present(32'hC);
        chk("stream_2nd_raddr", INST_RADDR, 32'h4);
        chk("stream_2nd_rdata", INST_RDATA, 32'h4 ^ KEY);
        idle(6);

        // Backpressure: memory not ready, fifth request held while stalled
        rready_i = 0;
        present(32'h10);
        present(32'h14);
        present(32'h18);
        present(32'h1C);
        rden_i = 1; addr_i = 32'h20;
        idle(3);
        chk("bp_stall", {31'b0, INST_STALL}, 32'h1);
        rready_i = 1;
        present(32'h20);
        idle(10);

        // Flush with two issued and one unissued request
        lat = 6;
        present(32'h40);
        present(32'h44);
        present(32'h48);
        rready_i = 0; flush_i = 1;
        tick();
        flush_i = 0; rready_i = 1;
        idle(10);
        chk("flush_count", {29'b0, dut_count()}, 32'h0);
        lat = 1;
        present(32'h100);
        idle(4);
        chk("flush_next_raddr", INST_RADDR, 32'h100);
        chk("flush_next_rdata", INST_RDATA, 32'h100 ^ KEY);

        // Flush in the same cycle as the response
        lat = 2;
        present(32'h200);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                flush_i = 1;
                tick();
                flush_i = 0;
                hit = 1;
            end else begin
                tick();
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $error("FAIL flush_coincident observed=no_response expected=response");
        end
        chk("fc_rvalid", {31'b0, INST_RVALID}, 32'h0);
        chk("fc_count", {29'b0, dut_count()}, 32'h0);
        idle(3);

        // Spurious response with an empty buffer
        spur_i = 1;
        tick();
        spur_i = 0;
        tick();
        chk("spur_count", {29'b0, dut_count()}, 32'h0);
        chk("spur_head", {29'b0, dut.head_q}, {29'b0, dut.issue_q});

        // Reset with three entries pending, responses still in flight
        lat = 4;
        present(32'h300);
        present(32'h304);
        present(32'h308);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("midrst_rvalid", {31'b0, INST_RVALID}, 32'h0);
        chk("midrst_raddr", INST_RADDR, 32'h0);
        chk("midrst_rdata", INST_RDATA, 32'h0);
        chk("midrst_stall", {31'b0, INST_STALL}, 32'h0);
        idle(8);
        chk("midrst_count", {29'b0, dut_count()}, 32'h0);

        // Random traffic
        rand_lat = 1;
        addr_i = $urandom() & 32'hFFFF_FFFC;
        for (int i = 0; i < 500; i++) begin
            if (last_acc || !rden_i) addr_i = $urandom() & 32'hFFFF_FFFC;
            rden_i   = ($urandom_range(0, 9) < 7);
            rready_i = ($urandom_range(0, 3) != 0);
            flush_i  = ($urandom_range(0, 19) == 0);
            rst_i    = ($urandom_range(0, 199) == 0);
            spur_i   = (mem_addr_q.size() == 0) && (n_iss == 0) && ($urandom_range(0, 9) == 0);
            tick();
        end
        rden_i = 0; flush_i = 0; rst_i = 0; spur_i = 0; rready_i = 1;
        idle(20);
        chk("final_count", {29'b0, dut_count()}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
